spi_register_responder: RTL
===========================

// Module: spi_register_responder
// PURPOSE
//  SPI slave (responder) end of the BMP280-style register protocol that the SPI command handler initiates.
//  Deserialises control/data bytes from an external SPI master and converts them into single-cycle
//  register-bus reads/writes; serialises read data back. Used as sensor model and as FPGA-side slave port.
//  Oversampled design: all SPI pins synchronised into clk; f_clk must be >= 8 x f_sck.
// PARAMETERS
//  PACKAGE_SIZE  8  bits per SPI byte and register data width; address width is PACKAGE_SIZE-1
//  SYNC_STAGES   2  synchroniser flops on sck/csb/sdi (>=2)
// PORTS
//  clk        in   1               system clock, single clock domain
//  rstb       in   1               asynchronous, active-high reset
//  sck        in   1               SPI clock from master (mode 0 or mode 3)
//  csb        in   1               SPI chip select, active low
//  sdi        in   1               serial data from master (MOSI)
//  sdo        out  1               serial data to master (MISO)
//  sdo_oe     out  1               sdo output enable (1 only while shifting read data)
//  reg_addr   out  PACKAGE_SIZE-1  register bus address
//  reg_wdata  out  PACKAGE_SIZE    register bus write data
//  reg_we     out  1               write strobe, 1 clk pulse
//  reg_re     out  1               read strobe, 1 clk pulse
//  reg_rdata  in   PACKAGE_SIZE    read data, valid exactly 1 clk after reg_re
//  busy       out  1               1 while a frame is in progress (csb low, state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0 (sdo=0, sdo_oe=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, busy=0); state IDLE.
//  Sync: SYNC_STAGES flops + 1 edge-detect flop per pin; sck rise/fall and csb fall/rise seen SYNC_STAGES+1 clk after pin.
//  Bits MSB first. sdi sampled on sck rising edge; sdo updated on sck falling edge (valid for modes 0 and 3).
//  Control byte = {rw, addr[PACKAGE_SIZE-2:0]}; rw=1 read, rw=0 write.
//  States:
//   IDLE : csb fall -> CTRL, bit counter=0. csb already low on leaving reset -> WAITCS.
//   CTRL : shift 8 bits; on 8th rising edge latch reg_addr=addr.
//          rw=0 -> WDATA. rw=1 -> pulse reg_re next clk, load reg_rdata into tx shifter 1 clk later, -> RDATA.
//   WDATA: shift 8 bits; on 8th rising: reg_wdata=byte, reg_we pulse 1 clk after, -> CTRL (next byte is a new
//          control byte: write bursts are addr/data pairs, no auto-increment).
//   RDATA: sdo_oe=1; each falling edge shifts next bit; tx MSB presented on first falling edge after load.
//          On 8th rising edge of each data byte: reg_addr+1 (wraps all-ones -> 0), reg_re pulse, reload shifter.
//          Read bursts continue until csb rise.
//   WAITCS: ignore sck/sdi, outputs idle; csb rise -> IDLE.
//  csb rise in any state -> IDLE within 1 clk of detection; partial byte discarded, no reg_we/reg_re issued
//   for it; sdo_oe=0, sdo=0. reg_we/reg_re already issued stand.
//  csb fall detected in same clk as sck edge: csb handled first, the sck edge ignored.
//  reg_we and reg_re never asserted in the same clk; each at most once per byte.
//  reg_rdata latency fixed at 1 clk; bus side must not stall.
//  Reset mid-frame: immediate return to reset values; remainder of frame ignored via WAITCS.
//  Extra sck edges with csb high: ignored. sdi while in RDATA: ignored.
// TESTING
//  1 Mode 0, csb low, send 0x15,0xA5, csb high -> one reg_we, reg_addr=0x15, reg_wdata=0xA5; sdo_oe stays 0.
//  2 Send 0x10,0x11,0x20,0x22 in one frame -> two reg_we: (0x10,0x11) then (0x20,0x22); no auto-increment.
//  3 Read 0xFE then 3 dummy bytes, bus returns addr^0x5A -> reg_re at 0x7E,0x7F,0x00,0x01 (wrap);
//    master receives 0x24,0x25,0x5A.
//  4 Write 0x15 then 5 bits of data, csb high -> no reg_we; busy=0; next frame decodes normally.
//  5 Assert rstb during 3rd data bit of a read -> outputs 0 immediately; rest of frame ignored (WAITCS);
//    next full frame works.
//  6 Mode 3 (sck idle high) read of 0x88, bus returns 0xC3 -> master samples 0xC3 on rising edges.

Source files
------------

// File: rtl/spi_register_responder.sv
// Oversampled SPI slave: turns {rw,addr} control bytes and data bytes from an external
// master into single-cycle register-bus reads/writes and shifts read data back out.
module spi_register_responder #(
   parameter int unsigned PACKAGE_SIZE = 8,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    sck,
   input  logic                    csb,
   input  logic                    sdi,
   output logic                    sdo,
   output logic                    sdo_oe,
   output logic [PACKAGE_SIZE-2:0] reg_addr,
   output logic [PACKAGE_SIZE-1:0] reg_wdata,
   output logic                    reg_we,
   output logic                    reg_re,
   input  logic [PACKAGE_SIZE-1:0] reg_rdata,
   output logic                    busy
);
   localparam int unsigned DW = PACKAGE_SIZE;
   localparam int unsigned AW = PACKAGE_SIZE - 1;
   localparam int unsigned CW = $clog2(PACKAGE_SIZE);
   localparam logic [CW-1:0] LAST_BIT = CW'(PACKAGE_SIZE - 1);

   typedef enum logic [2:0] {IDLE, CTRL, WDATA, RDATA, WAITCS} state_t;

   // Pin synchronisers: SYNC_STAGES flops plus one edge-detect flop each.
   logic [SYNC_STAGES:0] sck_q, csb_q, sdi_q;
   logic sck_rise, sck_fall, csb_rise, csb_fall, csb_cur, sdi_cur;

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         sck_q <= '0;
         csb_q <= '0;
         sdi_q <= '0;
      end else begin
         sck_q <= {sck_q[SYNC_STAGES-1:0], sck};
         csb_q <= {csb_q[SYNC_STAGES-1:0], csb};
         sdi_q <= {sdi_q[SYNC_STAGES-1:0], sdi};
      end
   end

   assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
   assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_q[SYNC_STAGES];
   assign csb_rise = csb_q[SYNC_STAGES-1] & ~csb_q[SYNC_STAGES];
   assign csb_fall = ~csb_q[SYNC_STAGES-1] & csb_q[SYNC_STAGES];
   assign csb_cur  = csb_q[SYNC_STAGES-1];
   assign sdi_cur  = sdi_q[SYNC_STAGES];

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [DW-2:0] rx_sh, rx_n;
   logic [DW-1:0] tx_sh, tx_n, tx_cur, rx_byte;
   logic          ld, ld_n;
   logic [AW-1:0] addr_n;
   logic [DW-1:0] wdata_n;
   logic          we_n, re_n, sdo_n, oe_n, busy_n;

   always_ff @(posedge clk or posedge rstb) begin
      if (rstb) begin
         state     <= IDLE;
         cnt       <= '0;
         rx_sh     <= '0;
         tx_sh     <= '0;
         ld        <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         sdo       <= 1'b0;
         sdo_oe    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         rx_sh     <= rx_n;
         tx_sh     <= tx_n;
         ld        <= ld_n;
         reg_addr  <= addr_n;
         reg_wdata <= wdata_n;
         reg_we    <= we_n;
         reg_re    <= re_n;
         sdo       <= sdo_n;
         sdo_oe    <= oe_n;
         busy      <= busy_n;
      end
   end

   // Next-state and output decode; a csb rise always wins over any sck edge.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      rx_n    = rx_sh;
      tx_n    = tx_sh;
      ld_n    = 1'b0;
      addr_n  = reg_addr;
      wdata_n = reg_wdata;
      we_n    = 1'b0;
      re_n    = 1'b0;
      sdo_n   = sdo;
      rx_byte = {rx_sh, sdi_cur};
      tx_cur  = ld ? reg_rdata : tx_sh;

      case (state)
         IDLE: begin
            if (csb_fall) begin
               state_n = CTRL;
               cnt_n   = '0;
            end else if (!csb_cur) begin
               state_n = WAITCS;
            end
         end
         WAITCS: begin
            if (csb_rise) state_n = IDLE;
         end
         CTRL: begin
            if (csb_rise) begin
               state_n = IDLE;
            end else if (sck_rise) begin
               rx_n  = rx_byte[DW-2:0];
               cnt_n = cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  cnt_n  = '0;
                  addr_n = rx_byte[AW-1:0];
                  if (rx_byte[DW-1]) begin
                     state_n = RDATA;
                     re_n    = 1'b1;
                  end else begin
                     state_n = WDATA;
                  end
               end
            end
         end
         WDATA: begin
            if (csb_rise) begin
               state_n = IDLE;
            end else if (sck_rise) begin
               rx_n  = rx_byte[DW-2:0];
               cnt_n = cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  cnt_n   = '0;
                  wdata_n = rx_byte;
                  we_n    = 1'b1;
                  state_n = CTRL;
               end
            end
         end
         RDATA: begin
            if (csb_rise) begin
               state_n = IDLE;
            end else begin
               // Read data arrives one clk after reg_re; load it the clk after that.
               ld_n = reg_re;
               tx_n = tx_cur;
               if (sck_fall) begin
                  sdo_n = tx_cur[DW-1];
                  tx_n  = {tx_cur[DW-2:0], 1'b0};
               end else if (sck_rise) begin
                  cnt_n = cnt + CW'(1);
                  if (cnt == LAST_BIT) begin
                     cnt_n  = '0;
                     addr_n = reg_addr + AW'(1);
                     re_n   = 1'b1;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (state_n != RDATA) sdo_n = 1'b0;
      oe_n   = (state_n == RDATA);
      busy_n = (state_n == CTRL) || (state_n == WDATA) || (state_n == RDATA);
   end

endmodule
